// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB types and helpers for the bus arbiter.
// Latency: none (types and a pure function only).
// Backpressure: n/a.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } trans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_t;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Wide enough to hold the largest remaining-beat count (15).
  localparam int BeatCntWidth = 4;

  // Beats in a fixed-length burst; SINGLE and undefined-length INCR report 1.
  function automatic logic [4:0] burst_len(burst_t b);
    case (b)
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter-side view of the shared AHB bus: requests and muxed bus state in, ownership out.
// Latency: none (wires only).
// Backpressure: ready is the only stall; the arbiter freezes while it is low.
interface ahb_arbiter_if #(
  parameter int NumManagers = 4,
  parameter int IdxWidth    = $clog2(NumManagers)
);
  logic [NumManagers-1:0] req;
  logic [NumManagers-1:0] lockReq;
  logic [2:0]             trans;
  logic [2:0]             burst;
  logic                   ready;
  logic [NumManagers-1:0] grant;
  logic [IdxWidth-1:0]    addrOwner;
  logic [IdxWidth-1:0]    dataOwner;
  logic                   mastLock;

  // Managers / shared-bus side.
  modport master (
    output req, lockReq, trans, burst, ready,
    input  grant, addrOwner, dataOwner, mastLock
  );

  // Arbiter side.
  modport slave (
    input  req, lockReq, trans, burst, ready,
    output grant, addrOwner, dataOwner, mastLock
  );
endinterface

// File: rtl/ahb_rr_picker.sv
// Picks the next bus owner from the request vector (round-robin after rr_ptr, or fixed priority).
// Latency: combinational.
// Backpressure: none; valid is low when nobody requests.
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int NumManagers = 4,
  parameter int IdxWidth    = $clog2(NumManagers)
) (
  input  logic [NumManagers-1:0] req,
  input  logic [IdxWidth-1:0]    rr_ptr,
  output logic [IdxWidth-1:0]    winner,
  output logic                   valid
);

`ifdef AHB_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^rr_ptr;

  // Lowest index wins: scan downward so the last hit is the smallest requester.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = NumManagers - 1; i >= 0; i--) begin
      if (req[IdxWidth'(i)]) begin
        winner = IdxWidth'(i);
        valid  = 1'b1;
      end
    end
  end
`else
  int idx;

  // Search rr_ptr+1 .. rr_ptr+NumManagers (mod N); scanning backward leaves the nearest hit.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = NumManagers; i >= 1; i--) begin
      idx = (int'(rr_ptr) + i) % NumManagers;
      if (req[IdxWidth'(idx)]) begin
        winner = IdxWidth'(idx);
        valid  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant that never splits fixed bursts or locked sequences.
// Latency: ownership changes one ready edge after the deciding transfer; dataOwner lags addrOwner by one ready edge.
// Backpressure: every register holds while ready is low. Optional macro AHB_ARB_FIXED_PRIO_EN selects fixed priority.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NumManagers = 4,
  parameter int IdxWidth    = $clog2(NumManagers),
  parameter int DefaultMgr  = 0
) (
  input logic          clk,
  input logic          reset,
  ahb_arbiter_if.slave bus
);

  localparam logic [IdxWidth-1:0] DefaultIdx = IdxWidth'(DefaultMgr);

  arb_state_t              state_q, state_d;
  logic [BeatCntWidth-1:0] beat_q, beat_d;
  logic [IdxWidth-1:0]     addr_q, addr_d;
  logic [IdxWidth-1:0]     data_q;
  logic [IdxWidth-1:0]     rr_q, rr_d;
  logic                    lock_q;

  // Outcome of an arbitration-state evaluation, shared by ARB and early burst termination.
  arb_state_t              arb_state;
  logic [BeatCntWidth-1:0] arb_beat;
  logic [IdxWidth-1:0]     arb_owner;
  logic [IdxWidth-1:0]     arb_rr;

  trans_t                  trans_v;
  burst_t                  burst_v;
  logic [4:0]              len;
  logic [IdxWidth-1:0]     winner;
  logic                    winner_vld;
  logic                    unused_trans;

  assign trans_v      = trans_t'(bus.trans[1:0]);
  assign burst_v      = burst_t'(bus.burst);
  assign len          = burst_len(burst_v);
  assign unused_trans = bus.trans[2];

  ahb_rr_picker #(
    .NumManagers (NumManagers),
    .IdxWidth    (IdxWidth)
  ) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_q),
    .winner (winner),
    .valid  (winner_vld)
  );

  // Arbitration decision: start a fixed burst, enter a lock, keep an active INCR owner, or hand over.
  always_comb begin
    arb_state = ARB;
    arb_beat  = '0;
    arb_owner = addr_q;
    arb_rr    = rr_q;
    if (trans_v == NONSEQ && len != 5'd1) begin
      arb_state = BURST;
      arb_beat  = BeatCntWidth'(len - 5'd1);
    end else if (bus.lockReq[addr_q] && bus.req[addr_q]) begin
      arb_state = LOCKED;
    end else if ((trans_v == BUSY || trans_v == SEQ) && bus.req[addr_q]) begin
      arb_state = ARB;
    end else if (winner_vld) begin
      if (winner != addr_q) begin
        arb_owner = winner;
        arb_rr    = winner;
      end
    end else if (DefaultIdx != addr_q) begin
      arb_owner = DefaultIdx;
      arb_rr    = DefaultIdx;
    end
  end

  // Next-state logic: bursts count down on SEQ, locks release only on IDLE with lockReq dropped.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    rr_d    = rr_q;
    case (state_q)
      ARB: begin
        state_d = arb_state;
        beat_d  = arb_beat;
        addr_d  = arb_owner;
        rr_d    = arb_rr;
      end
      BURST: begin
        if (trans_v == SEQ) begin
          if (beat_q <= BeatCntWidth'(1)) begin
            beat_d  = '0;
            state_d = ARB;
          end else begin
            beat_d = beat_q - BeatCntWidth'(1);
          end
        end else if (trans_v == IDLE || trans_v == NONSEQ) begin
          state_d = arb_state;
          beat_d  = arb_beat;
          addr_d  = arb_owner;
          rr_d    = arb_rr;
        end
      end
      LOCKED: begin
        if (!bus.lockReq[addr_q] && trans_v == IDLE) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Ownership and FSM registers advance only on completed transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      beat_q  <= '0;
      addr_q  <= DefaultIdx;
      data_q  <= DefaultIdx;
      lock_q  <= 1'b0;
    end else if (bus.ready) begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      data_q  <= addr_q;
      lock_q  <= bus.lockReq[addr_q];
    end
  end

`ifdef AHB_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^rr_d;
  assign rr_q      = '0;
`else
  // Rotation pointer remembers the last manager that won a handover.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= DefaultIdx;
    end else if (bus.ready) begin
      rr_q <= rr_d;
    end
  end
`endif

  assign bus.grant     = {{(NumManagers-1){1'b0}}, 1'b1} << addr_q;
  assign bus.addrOwner = addr_q;
  assign bus.dataOwner = data_q;
  assign bus.mastLock  = lock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: table of per-cycle vectors plus hand-driven reset sequences.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: ready is driven low in selected vectors to exercise stalls.
module tb_ahb_arbiter;

  localparam logic [2:0] T_IDLE = 3'd0;
  localparam logic [2:0] T_BUSY = 3'd1;
  localparam logic [2:0] T_NS   = 3'd2;
  localparam logic [2:0] T_SEQ  = 3'd3;
  localparam logic [2:0] B_SGL  = 3'd0;
  localparam logic [2:0] B_I4   = 3'd3;
  localparam logic [2:0] B_I8   = 3'd5;

  logic clk = 1'b0;
  logic rst;

  ahb_arbiter_if #(.NumManagers(4)) bus ();

  ahb_arbiter #(
    .NumManagers (4),
    .DefaultMgr  (0)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lck;
    logic [2:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic [3:0] g;
    logic [1:0] ao;
    logic [1:0] dow;
    logic       ml;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] lck,
                              input logic [2:0] trans, input logic [2:0] burst,
                              input logic rdy, input logic [3:0] g,
                              input logic [1:0] ao, input logic [1:0] dow,
                              input logic ml);
    vec_t v;
    v.req = req; v.lck = lck; v.trans = trans; v.burst = burst; v.rdy = rdy;
    v.g = g; v.ao = ao; v.dow = dow; v.ml = ml;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic [3:0] g, input logic [1:0] ao,
                            input logic [1:0] dow, input logic ml);
    check("grant", idx, bus.grant, g);
    check("addrOwner", idx, {2'b00, bus.addrOwner}, {2'b00, ao});
    check("dataOwner", idx, {2'b00, bus.dataOwner}, {2'b00, dow});
    check("mastLock", idx, {3'b000, bus.mastLock}, {3'b000, ml});
  endtask

  task automatic drive(input vec_t v);
    bus.req     = v.req;
    bus.lockReq = v.lck;
    bus.trans   = v.trans;
    bus.burst   = v.burst;
    bus.ready   = v.rdy;
  endtask

  task automatic apply_check(input int i);
    drive(vecs[i]);
    @(posedge clk);
    #1;
    check_outs(i, vecs[i].g, vecs[i].ao, vecs[i].dow, vecs[i].ml);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      apply_check(i);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.req     = '0;
    bus.lockReq = '0;
    bus.trans   = T_IDLE;
    bus.burst   = B_SGL;
    bus.ready   = 1'b1;

    // 0..9: idle bus parks on the default manager.
    for (int i = 0; i < 10; i++) vecs.push_back(mk(4'b0000, 4'b0000, T_IDLE, B_SGL, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0));
    // 10..15: M1/M2 alternate on SINGLE/IDLE; last step is a ready stall.
    vecs.push_back(mk(4'b0110, 4'b0000, T_IDLE, B_SGL, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_NS,   B_SGL, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_NS,   B_SGL, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_IDLE, B_SGL, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_NS,   B_SGL, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_IDLE, B_SGL, 1'b0, 4'b0010, 2'd1, 2'd2, 1'b0));
    // 16..20: M1 INCR4, M2 requests on beat 2, handover after the last SEQ.
    vecs.push_back(mk(4'b0010, 4'b0000, T_NS,   B_I4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_SEQ,  B_I4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_SEQ,  B_I4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_SEQ,  B_I4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0100, 4'b0000, T_IDLE, B_SGL, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0));
    // 21..28: M2 INCR4 with two stalls and a BUSY; M2 drops req mid-burst.
    vecs.push_back(mk(4'b0110, 4'b0000, T_NS,   B_I4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_SEQ,  B_I4,  1'b0, 4'b0100, 2'd2, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_SEQ,  B_I4,  1'b0, 4'b0100, 2'd2, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_SEQ,  B_I4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_BUSY, B_I4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0010, 4'b0000, T_SEQ,  B_I4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0010, 4'b0000, T_SEQ,  B_I4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0010, 4'b0000, T_IDLE, B_SGL, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0));
    // 29..35: M3 locked for three transfers while M0 waits; release needs IDLE.
    vecs.push_back(mk(4'b1000, 4'b1000, T_IDLE, B_SGL, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b0));
    vecs.push_back(mk(4'b1001, 4'b1000, T_NS,   B_SGL, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1));
    vecs.push_back(mk(4'b1001, 4'b1000, T_NS,   B_SGL, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1));
    vecs.push_back(mk(4'b1001, 4'b1000, T_NS,   B_SGL, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1));
    vecs.push_back(mk(4'b1001, 4'b0000, T_NS,   B_SGL, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b0));
    vecs.push_back(mk(4'b1001, 4'b0000, T_IDLE, B_SGL, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b0));
    vecs.push_back(mk(4'b1001, 4'b0000, T_IDLE, B_SGL, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0));
    // 36..40: M1 starts INCR8, beats 1..4.
    vecs.push_back(mk(4'b0010, 4'b0000, T_IDLE, B_SGL, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0010, 4'b0000, T_NS,   B_I8,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_SEQ,  B_I8,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_SEQ,  B_I8,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, T_SEQ,  B_I8,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0));
    // 41: first arbitration after reset searches from the default manager.
    vecs.push_back(mk(4'b0110, 4'b0000, T_IDLE, B_SGL, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0));

    #1;
    check_outs(-1, 4'b0001, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_vecs(0, 40);

    // Beat 5 of the INCR8: reset lands mid-cycle and must act without a clock.
    @(negedge clk);
    bus.req   = 4'b0110;
    bus.trans = T_SEQ;
    bus.burst = B_I8;
    #2;
    rst = 1'b1;
    #1;
    check_outs(-2, 4'b0001, 2'd0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check_outs(-3, 4'b0001, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply_check(41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
